// File: rtl/dizy_keystream_ctrl_if.sv
// Request, core-control and keystream signals of the DIZY keystream sequencer.
// Latency: none (wires only).
// Backpressure: ks_valid/ks_ready handshake on the keystream side.
interface dizy_keystream_ctrl_if #(
  parameter int SIZE_STATE = 128,
  parameter int SIZE_KEY   = 80,
  parameter int SIZE_OUT   = 64,
  parameter int CNT_W      = 16
);
  // system-side request
  logic                  start;
  logic                  abort;
  logic [SIZE_KEY-1:0]   key_in;
  logic [SIZE_KEY-1:0]   iv_in;
  logic [CNT_W-1:0]      num_blocks;
  logic                  busy;
  logic                  done;
  // core control
  logic                  core_load;
  logic                  core_next;
  logic [SIZE_KEY-1:0]   core_key;
  logic [SIZE_STATE-1:0] core_state;
  // keystream output
  logic [SIZE_OUT-1:0]   ks_data;
  logic                  ks_valid;
  logic                  ks_ready;

  // sequencer side
  modport slave (
    input  start, abort, key_in, iv_in, num_blocks, core_state, ks_ready,
    output core_load, core_next, core_key, ks_data, ks_valid, busy, done
  );

  // requester / core / consumer side
  modport master (
    output start, abort, key_in, iv_in, num_blocks, core_state, ks_ready,
    input  core_load, core_next, core_key, ks_data, ks_valid, busy, done
  );
endinterface

// File: rtl/dizy_keystream_ctrl.sv
// Sequencer for an unrolled DIZY core: key load, IV injection, warm-up, then keystream.
// Latency: first word 3+INIT_ITER cycles after an accepted start; then one word per cycle.
// Backpressure: core only advances on a ks_valid&&ks_ready fire, so ks_data holds while stalled.
module dizy_keystream_ctrl #(
  parameter int SIZE_STATE = 128,
  parameter int SIZE_KEY   = 80,
  parameter int SIZE_OUT   = 64,
  parameter int INIT_ITER  = 4,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst,
  dizy_keystream_ctrl_if.slave bus
);

  localparam int WW = (INIT_ITER > 0) ? $clog2(INIT_ITER + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_K  = 3'd1,
    LOAD_IV = 3'd2,
    WARMUP  = 3'd3,
    STREAM  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SIZE_KEY-1:0] key_q, key_d;
  logic [SIZE_KEY-1:0] iv_q, iv_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [WW-1:0]       warm_q, warm_d;
  logic                done_q, done_d;

  logic                fire;
  logic                unused_state_bits;

  // Low core-state bits are not part of the keystream word.
  assign unused_state_bits = ^bus.core_state[SIZE_STATE-SIZE_OUT-1:0];

  assign fire = (state_q == STREAM) && bus.ks_ready;

  // State and capture registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      iv_q    <= '0;
      rem_q   <= '0;
      warm_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      rem_q   <= rem_d;
      warm_q  <= warm_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; a zero block count finishes straight out of initialisation.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    iv_d    = iv_q;
    rem_d   = rem_q;
    warm_d  = warm_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          key_d   = bus.key_in;
          iv_d    = bus.iv_in;
          rem_d   = bus.num_blocks;
          state_d = LOAD_K;
        end
      end
      LOAD_K: begin
        state_d = LOAD_IV;
      end
      LOAD_IV: begin
        if (INIT_ITER > 0) begin
          warm_d  = WW'(INIT_ITER);
          state_d = WARMUP;
        end else if (rem_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      WARMUP: begin
        warm_d = warm_q - WW'(1);
        if (warm_q == WW'(1)) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (fire) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel wins over everything, including a same-cycle start, and suppresses done.
    if (bus.abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // Core strobes and key bus; core_next in STREAM is the single Mealy path via ks_ready.
  always_comb begin
    bus.core_load = 1'b0;
    bus.core_next = 1'b0;
    bus.core_key  = '0;
    bus.ks_valid  = 1'b0;
    case (state_q)
      LOAD_K: begin
        bus.core_load = 1'b1;
        bus.core_key  = key_q;
      end
      LOAD_IV: begin
        bus.core_next = 1'b1;
        bus.core_key  = iv_q;
      end
      WARMUP: begin
        bus.core_next = 1'b1;
      end
      STREAM: begin
        bus.ks_valid  = 1'b1;
        bus.core_next = fire && (rem_q != CNT_W'(1));
      end
      default: begin
        bus.core_load = 1'b0;
      end
    endcase
  end

  assign bus.ks_data = bus.core_state[SIZE_STATE-1 -: SIZE_OUT];
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dizy_keystream_ctrl.sv
// Bench for dizy_keystream_ctrl: two instances (INIT_ITER=4 and 0) each driving a stand-in core.
// Latency: checks are cycle-exact against the request timeline.
// Backpressure: directed and random ks_ready patterns, checked against a word-sequence model.
module tb_dizy_keystream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dizy_keystream_ctrl_if b0 ();
  dizy_keystream_ctrl_if b1 ();

  dizy_keystream_ctrl #(.INIT_ITER(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dizy_keystream_ctrl #(.INIT_ITER(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // shared stimulus
  logic        st0, st1, ab, rdy;
  logic [79:0] key_v, iv_v;
  logic [15:0] num_v;
  assign b0.start = st0;    assign b1.start = st1;
  assign b0.abort = ab;     assign b1.abort = ab;
  assign b0.ks_ready = rdy; assign b1.ks_ready = rdy;
  assign b0.key_in = key_v; assign b1.key_in = key_v;
  assign b0.iv_in = iv_v;   assign b1.iv_in = iv_v;
  assign b0.num_blocks = num_v; assign b1.num_blocks = num_v;

  // Stand-in core: load and advance functions
  function automatic logic [127:0] core_load_f(input logic [79:0] k);
    return {k, ~k[47:0]};
  endfunction
  function automatic logic [127:0] core_step_f(input logic [127:0] s, input logic [79:0] k);
    return {s[114:0], s[127:115]} ^ (s >> 7) ^ {k, 48'h0}
           ^ 128'h9E3779B97F4A7C15_0123456789ABCDEF;
  endfunction

  logic [127:0] cs0, cs1;
  assign b0.core_state = cs0;
  assign b1.core_state = cs1;
  always @(posedge clk or posedge rst) begin
    if (rst) cs0 <= '0;
    else if (b0.core_load) cs0 <= core_load_f(b0.core_key);
    else if (b0.core_next) cs0 <= core_step_f(cs0, b0.core_key);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) cs1 <= '0;
    else if (b1.core_load) cs1 <= core_load_f(b1.core_key);
    else if (b1.core_next) cs1 <= core_step_f(cs1, b1.core_key);
  end

  // observation mux
  bit          sel;
  logic        o_load, o_next, o_valid, o_busy, o_done;
  logic [79:0] o_key;
  logic [63:0] o_data;
  assign o_load  = sel ? b1.core_load : b0.core_load;
  assign o_next  = sel ? b1.core_next : b0.core_next;
  assign o_valid = sel ? b1.ks_valid  : b0.ks_valid;
  assign o_busy  = sel ? b1.busy      : b0.busy;
  assign o_done  = sel ? b1.done      : b0.done;
  assign o_key   = sel ? b1.core_key  : b0.core_key;
  assign o_data  = sel ? b1.ks_data   : b0.ks_data;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".core_load"}, o_load, 0);
    check({tag, ".core_next"}, o_next, 0);
    check({tag, ".core_key"}, o_key, 0);
    check({tag, ".ks_data"}, o_data, 0);
    check({tag, ".ks_valid"}, o_valid, 0);
    check({tag, ".busy"}, o_busy, 0);
    check({tag, ".done"}, o_done, 0);
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One full request, checked cycle by cycle; returns at the negedge of the done cycle.
  // mode 0: ready always 1, 1: random ready, 2: ready pattern 1,0,0,1,0,1 repeating
  task automatic run_request(input bit s, input logic [79:0] k, input logic [79:0] iv,
                             input logic [15:0] n, input int mode);
    int           init;
    int           fires;
    int           limit;
    logic         r;
    logic [127:0] m;
    logic [5:0]   pat;
    pat   = 6'b101001;
    init  = s ? 0 : 4;
    sel   = s;
    rdy   = 1'b0;
    key_v = k;
    iv_v  = iv;
    num_v = n;
    if (s) st1 = 1'b1; else st0 = 1'b1;
    step();
    st0 = 1'b0; st1 = 1'b0;
    key_v = rand80(); iv_v = rand80(); num_v = 16'($urandom());
    #1;
    check("load_k.core_load", o_load, 1);
    check("load_k.core_next", o_next, 0);
    check("load_k.core_key", o_key, k);
    check("load_k.busy", o_busy, 1);
    step(); #1;
    check("load_iv.core_next", o_next, 1);
    check("load_iv.core_load", o_load, 0);
    check("load_iv.core_key", o_key, iv);
    for (int i = 0; i < init; i++) begin
      step(); #1;
      check("warmup.core_next", o_next, 1);
      check("warmup.core_key", o_key, 0);
      check("warmup.ks_valid", o_valid, 0);
    end
    step();
    // expected core state at the first word: load, inject IV, then blank warm-up rounds
    m = core_load_f(k);
    m = core_step_f(m, iv);
    repeat (init) m = core_step_f(m, '0);
    if (n == 16'd0) begin
      #1;
      check("zero.done", o_done, 1);
      check("zero.busy", o_busy, 0);
      check("zero.ks_valid", o_valid, 0);
      return;
    end
    fires = 0;
    limit = 4 * int'(n) + 20;
    for (int c = 0; c < limit && fires < int'(n); c++) begin
      if (c > 0) step();
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = pat[c % 6];
      endcase
      rdy = r;
      #1;
      check("stream.ks_valid", o_valid, 1);
      check("stream.ks_data", o_data, m[127:64]);
      check("stream.core_next", o_next, (r && (fires < int'(n) - 1)) ? 1 : 0);
      check("stream.core_load", o_load, 0);
      check("stream.done", o_done, 0);
      if (r) begin
        fires++;
        if (fires < int'(n)) m = core_step_f(m, '0);
      end
    end
    check("stream.fires", fires, n);
    step();
    rdy = 1'b0;
    #1;
    check("end.done", o_done, 1);
    check("end.busy", o_busy, 0);
    check("end.ks_valid", o_valid, 0);
    check("end.core_next", o_next, 0);
  endtask

  logic [79:0] basic_key, basic_iv;
  int          loads;
  bit          seen_done;

  initial begin
    st0 = 0; st1 = 0; ab = 0; rdy = 0;
    key_v = '0; iv_v = '0; num_v = '0;
    sel = 0;
    basic_key = 80'h0123_4567_89AB_CDEF_F00D;
    basic_iv  = 80'hDEAD_BEEF_CAFE_1234_5678;

    // reset state
    rst = 1'b1;
    #1;
    sel = 0; #0 check_zero("reset.u0");
    sel = 1; #1 check_zero("reset.u1");
    step(); step();
    rst = 1'b0;
    step();

    // basic request, then a back-to-back request issued in the done cycle
    run_request(0, basic_key, basic_iv, 16'd3, 0);
    run_request(0, rand80(), rand80(), 16'd2, 1);
    step();

    // backpressure pattern over 5 words
    run_request(0, rand80(), rand80(), 16'd5, 2);
    step();

    // zero count on both instances
    run_request(0, rand80(), rand80(), 16'd0, 0);
    step();
    run_request(1, rand80(), rand80(), 16'd0, 0);
    step();

    // random requests with random ready
    for (int i = 0; i < 4; i++) begin
      run_request(0, rand80(), rand80(), 16'($urandom_range(1, 8)), 1);
      step();
    end

    // abort during warm-up
    sel = 0;
    key_v = rand80(); num_v = 16'd4;
    st0 = 1'b1;
    step(); st0 = 1'b0;   // LOAD_K
    step();               // LOAD_IV
    step(); #1;           // first warm-up cycle
    check("abort.pre.core_next", o_next, 1);
    ab = 1'b1;
    step(); ab = 1'b0; #1;
    check("abort.busy", o_busy, 0);
    check("abort.core_next", o_next, 0);
    check("abort.core_load", o_load, 0);
    check("abort.done", o_done, 0);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      check("abort.after.done", o_done, 0);
      check("abort.after.busy", o_busy, 0);
    end

    // start and abort together in IDLE: request refused
    st0 = 1'b1; ab = 1'b1;
    step(); st0 = 1'b0; ab = 1'b0; #1;
    check("start_abort.busy", o_busy, 0);
    check("start_abort.core_load", o_load, 0);
    step();

    // start held while busy is ignored
    rdy = 1'b1; num_v = 16'd2; key_v = rand80(); iv_v = rand80();
    st0 = 1'b1;
    step();
    loads = 0; seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (o_load) loads++;
      if (o_done) begin
        seen_done = 1;
        break;
      end
      if (c == 3) st0 = 1'b0;
      step();
    end
    st0 = 1'b0;
    check("busy_start.load_count", loads, 1);
    check("busy_start.done_seen", seen_done, 1);
    step();

    // asynchronous reset in the middle of streaming
    rdy = 1'b1; num_v = 16'd10; key_v = rand80(); iv_v = rand80();
    st0 = 1'b1;
    step(); st0 = 1'b0;
    repeat (8) step();
    #1;
    check("pre_rst.ks_valid", o_valid, 1);
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    step(); rst = 1'b0;
    step();
    run_request(0, basic_key, basic_iv, 16'd3, 0);
    step();

    // no warm-up, maximum block count
    run_request(1, rand80(), rand80(), 16'hFFFF, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
